// File: rtl/alu_seq.sv
// Key-handshaked integer ALU: single-cycle add/sub/logic/shift, iterative limb multiplier.
// Define ALU_DIV_EN to add the restoring unsigned divider (`DIVU / `REMU).
`ifndef KEY_SIZE
`define KEY_SIZE 4
`endif
`ifndef OPCODE_SIZE
`define OPCODE_SIZE 4
`define ADD  4'd0
`define SUB  4'd1
`define MUL  4'd2
`define AND  4'd3
`define OR   4'd4
`define XOR  4'd5
`define SHL  4'd6
`define SHR  4'd7
`define SRA  4'd8
`define DIVU 4'd9
`define REMU 4'd10
`endif

module alu_seq #(
   parameter int WIDTH = 32,
   parameter int LIMB  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    en,
   input  logic [`KEY_SIZE-1:0]    key_in,
   input  logic [`OPCODE_SIZE-1:0] op,
   input  logic [WIDTH-1:0]        inA,
   input  logic [WIDTH-1:0]        inB,
   output logic [`KEY_SIZE-1:0]    key_out,
   output logic [WIDTH-1:0]        out,
   output logic [2:0]              flags,
   output logic                    busy
);

   localparam int N  = WIDTH / LIMB;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = $clog2(WIDTH);

   typedef enum logic [1:0] {stIdle, stMul, stDone, stDiv} stateT;

   stateT                 state;
   logic [`KEY_SIZE-1:0]  keyL;
   logic [WIDTH-1:0]      aL, bL, acc;
   logic                  negL;
   logic [IW-1:0]         limbI, limbJ;

   // Single-cycle datapath works straight off the input operands.
   logic [WIDTH-1:0] scRes;
   logic             scOvf;
   logic [SW-1:0]    shAmt;
   logic [2:0]       scFlags;

   always_comb begin
      scRes = '0;
      scOvf = 1'b0;
      shAmt = inB[SW-1:0];
      case (op)
         `ADD: begin
            scRes = inA + inB;
            scOvf = (inA[WIDTH-1] == inB[WIDTH-1]) && (scRes[WIDTH-1] != inA[WIDTH-1]);
         end
         `SUB: begin
            scRes = inA - inB;
            scOvf = (inA[WIDTH-1] != inB[WIDTH-1]) && (scRes[WIDTH-1] != inA[WIDTH-1]);
         end
         `AND: scRes = inA & inB;
         `OR:  scRes = inA | inB;
         `XOR: scRes = inA ^ inB;
         `SHL: scRes = inA << shAmt;
         `SHR: scRes = inA >> shAmt;
         `SRA: scRes = $signed(inA) >>> shAmt;
         default: scRes = '0;
      endcase
      scFlags = {scOvf, scRes[WIDTH-1], scRes == '0};
   end

   // Multiplier: magnitudes are multiplied limb by limb, sign applied at the end.
   logic [WIDTH-1:0]   absA, absB, accNext, mulRes;
   logic [LIMB-1:0]    aLimb, bLimb;
   logic [2*LIMB-1:0]  pp;
   logic [2*WIDTH-1:0] ppWide;
   logic               mulLast;

   assign absA    = inA[WIDTH-1] ? -inA : inA;
   assign absB    = inB[WIDTH-1] ? -inB : inB;
   assign aLimb   = LIMB'(aL >> (limbI * LIMB));
   assign bLimb   = LIMB'(bL >> (limbJ * LIMB));
   assign pp      = {{LIMB{1'b0}}, aLimb} * {{LIMB{1'b0}}, bLimb};
   assign ppWide  = (2*WIDTH)'(pp) << ((limbI + limbJ) * LIMB);
   assign accNext = acc + ppWide[WIDTH-1:0];
   assign mulRes  = negL ? -accNext : accNext;
   assign mulLast = (limbI == IW'(N - 1));

`ifdef ALU_DIV_EN
   // Restoring divider: quo starts as the dividend and fills with quotient bits.
   logic [WIDTH-1:0] quo, rem, remNext, quoNext, divRes;
   logic [WIDTH:0]   remShift, trial;
   logic [SW-1:0]    cnt;
   logic             divIsRem, divGeq;

   assign remShift = {rem, quo[WIDTH-1]};
   assign trial    = remShift - {1'b0, bL};
   assign divGeq   = ~trial[WIDTH];
   assign remNext  = divGeq ? trial[WIDTH-1:0] : remShift[WIDTH-1:0];
   assign quoNext  = {quo[WIDTH-2:0], divGeq};
   assign divRes   = divIsRem ? remNext : quoNext;
`endif

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state   <= stIdle;
         out     <= '0;
         key_out <= '0;
         flags   <= 3'b001;
         busy    <= 1'b0;
         keyL    <= '0;
         aL      <= '0;
         bL      <= '0;
         acc     <= '0;
         negL    <= 1'b0;
         limbI   <= '0;
         limbJ   <= '0;
`ifdef ALU_DIV_EN
         quo      <= '0;
         rem      <= '0;
         cnt      <= '0;
         divIsRem <= 1'b0;
`endif
      end else if (en) begin
         case (state)
            stIdle: begin
               if (!busy && key_in != '0 && key_in != key_out) begin
                  keyL <= key_in;
                  if (op == `MUL) begin
                     aL      <= absA;
                     bL      <= absB;
                     negL    <= inA[WIDTH-1] ^ inB[WIDTH-1];
                     acc     <= '0;
                     limbI   <= '0;
                     limbJ   <= '0;
                     busy    <= 1'b1;
                     key_out <= '0;
                     state   <= stMul;
                  end
`ifdef ALU_DIV_EN
                  else if (op == `DIVU || op == `REMU) begin
                     quo      <= inA;
                     rem      <= '0;
                     bL       <= inB;
                     cnt      <= '0;
                     divIsRem <= (op == `REMU);
                     busy     <= 1'b1;
                     key_out  <= '0;
                     state    <= stDiv;
                  end
`endif
                  else begin
                     out     <= scRes;
                     flags   <= scFlags;
                     key_out <= key_in;
                  end
               end
            end
            stMul: begin
               acc <= accNext;
               if (mulLast) begin
                  out     <= mulRes;
                  flags   <= {1'b0, mulRes[WIDTH-1], mulRes == '0};
                  key_out <= keyL;
                  busy    <= 1'b0;
                  state   <= stDone;
               end else if (limbI + limbJ == IW'(N - 1)) begin
                  limbI <= limbI + IW'(1);
                  limbJ <= '0;
               end else begin
                  limbJ <= limbJ + IW'(1);
               end
            end
`ifdef ALU_DIV_EN
            stDiv: begin
               rem <= remNext;
               quo <= quoNext;
               cnt <= cnt + SW'(1);
               if (cnt == SW'(WIDTH - 1)) begin
                  out     <= divRes;
                  flags   <= {bL == '0, divRes[WIDTH-1], divRes == '0};
                  key_out <= keyL;
                  busy    <= 1'b0;
                  state   <= stDone;
               end
            end
`endif
            // DONE lasts one cycle so a new accept lands the cycle after it.
            default: state <= stIdle;
         endcase
      end
   end

endmodule
